// File: rtl/mips_cpu_regfile_scoreboard_if.sv
// ----------------------------------------------------------------------------
// mips_cpu_regfile_scoreboard_if
//   Bus bundle between decode and the register file / pending scoreboard.
//   master : decode side. Drives the write port, the read indices and the
//            multi-cycle producer issue. Receives the read data, the pending
//            flags, stall and pending_count.
//   slave  : register file side. Sees the same signals in the opposite
//            direction.
// ----------------------------------------------------------------------------
interface mips_cpu_regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Write port
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  // Read ports
  logic [ADDR_WIDTH-1:0] read_reg_1;
  logic [ADDR_WIDTH-1:0] read_reg_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [DATA_WIDTH-1:0] read_data_v0;
  // Scoreboard
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_reg;
  logic                  read_pending_1;
  logic                  read_pending_2;
  logic                  stall;
  logic [ADDR_WIDTH:0]   pending_count;

  modport master (
    output write_enable, write_reg, write_data,
    output read_reg_1, read_reg_2,
    output issue_valid, issue_reg,
    input  read_data_1, read_data_2, read_data_v0,
    input  read_pending_1, read_pending_2, stall, pending_count
  );

  modport slave (
    input  write_enable, write_reg, write_data,
    input  read_reg_1, read_reg_2,
    input  issue_valid, issue_reg,
    output read_data_1, read_data_2, read_data_v0,
    output read_pending_1, read_pending_2, stall, pending_count
  );
endinterface

// File: rtl/mips_cpu_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// mips_cpu_regfile_scoreboard
//   MIPS general-purpose register file with two combinational read ports, one
//   synchronous write port and a $v0 debug tap, plus a per-register pending
//   scoreboard for multi-cycle producers (loads, mult/div). Lives in decode
//   and drives the operand reads and the decode stall.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears registers and scoreboard
//   rf_if  : slave side of mips_cpu_regfile_scoreboard_if (write port, read
//            ports, $v0 tap, issue, pending flags, stall, pending_count)
// Parameters
//   DATA_WIDTH : register width
//   ADDR_WIDTH : index width, depth = 2**ADDR_WIDTH (min 2)
//   BYPASS     : 1 forwards same-cycle write data (and write-clears of the
//                pending bit) to the read ports; 0 reads see stored state only
// ----------------------------------------------------------------------------
module mips_cpu_regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic clk,
  input  logic reset,
  mips_cpu_regfile_scoreboard_if.slave rf_if
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] V0_IDX  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  logic we_s;
  logic issue_s;
  logic set_new_s;
  logic clr_old_s;

  // Read mux: r0 is hard zero, otherwise optionally forward the write port.
  function automatic logic [DATA_WIDTH-1:0] read_value(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wreg,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] val;
    if (idx == ZERO_IDX) begin
      val = {DATA_WIDTH{1'b0}};
    end else if ((BYPASS != 0) && we && (wreg == idx)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Pending lookup: a same-cycle writeback hides the pending bit when bypassing.
  function automatic logic read_pend(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DEPTH-1:0]      pend,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wreg
  );
    logic p;
    if ((BYPASS != 0) && we && (wreg == idx)) begin
      p = 1'b0;
    end else begin
      p = pend[idx];
    end
    return p;
  endfunction

  // Qualified write/issue strobes; index 0 is never written or pending.
  always_comb begin
    we_s    = rf_if.write_enable && (rf_if.write_reg != ZERO_IDX);
    issue_s = rf_if.issue_valid && (rf_if.issue_reg != ZERO_IDX);
  end

  // Scoreboard next state: clear on writeback, then set on issue so set wins.
  always_comb begin
    pending_d = pending_q;
    if (we_s) begin
      pending_d[rf_if.write_reg] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_s) begin
      pending_d[rf_if.issue_reg] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // Counter delta tracks popcount: a new pending reg adds, a retired one subtracts.
  always_comb begin
    set_new_s = issue_s && !pending_q[rf_if.issue_reg];
    clr_old_s = we_s && pending_q[rf_if.write_reg]
                && !(issue_s && (rf_if.issue_reg == rf_if.write_reg));
    count_d   = count_q + CW'(set_new_s) - CW'(clr_old_s);
  end

  // Register array, scoreboard and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= {DATA_WIDTH{1'b0}};
      end
      pending_q <= {DEPTH{1'b0}};
      count_q   <= {CW{1'b0}};
    end else begin
      if (we_s) begin
        regs_q[rf_if.write_reg] <= rf_if.write_data;
      end
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Combinational read ports, $v0 tap and stall.
  always_comb begin
    rf_if.read_data_1    = read_value(rf_if.read_reg_1, regs_q[rf_if.read_reg_1],
                                      rf_if.write_enable, rf_if.write_reg, rf_if.write_data);
    rf_if.read_data_2    = read_value(rf_if.read_reg_2, regs_q[rf_if.read_reg_2],
                                      rf_if.write_enable, rf_if.write_reg, rf_if.write_data);
    rf_if.read_data_v0   = read_value(V0_IDX, regs_q[V0_IDX],
                                      rf_if.write_enable, rf_if.write_reg, rf_if.write_data);
    rf_if.read_pending_1 = read_pend(rf_if.read_reg_1, pending_q,
                                     rf_if.write_enable, rf_if.write_reg);
    rf_if.read_pending_2 = read_pend(rf_if.read_reg_2, pending_q,
                                     rf_if.write_enable, rf_if.write_reg);
    rf_if.stall          = rf_if.read_pending_1 | rf_if.read_pending_2;
    rf_if.pending_count  = count_q;
  end

endmodule

// File: tb/tb_mips_cpu_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_mips_cpu_regfile_scoreboard
//   Scoreboard-style bench for mips_cpu_regfile_scoreboard (BYPASS=1).
//   Expected output values are queued as stimulus is driven and popped and
//   compared against the DUT outputs once they have settled.
// ----------------------------------------------------------------------------
module tb_mips_cpu_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum int { K_RD1, K_RD2, K_V0, K_PEND1, K_PEND2, K_STALL, K_COUNT } kind_t;

  typedef struct {
    kind_t       kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  mips_cpu_regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

  mips_cpu_regfile_scoreboard #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BYPASS    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf_if (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input kind_t kind, input string tag, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the queue against the DUT.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD1:   obs = rf_if.read_data_1;
        K_RD2:   obs = rf_if.read_data_2;
        K_V0:    obs = rf_if.read_data_v0;
        K_PEND1: obs = {31'd0, rf_if.read_pending_1};
        K_PEND2: obs = {31'd0, rf_if.read_pending_2};
        K_STALL: obs = {31'd0, rf_if.stall};
        K_COUNT: obs = {26'd0, rf_if.pending_count};
        default: obs = 32'hxxxx_xxxx;
      endcase
      check_value(e.tag, obs, e.exp);
    end
  endtask

  // One clock edge; inputs are changed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.write_enable = 1'b0;
    rf_if.write_reg    = 5'd0;
    rf_if.write_data   = 32'd0;
    rf_if.issue_valid  = 1'b0;
    rf_if.issue_reg    = 5'd0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    rf_if.write_enable = 1'b1;
    rf_if.write_reg    = r;
    rf_if.write_data   = d;
  endtask

  task automatic iss(input logic [4:0] r);
    rf_if.issue_valid = 1'b1;
    rf_if.issue_reg   = r;
  endtask

  // Run-time bound.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    idle();
    rf_if.read_reg_1 = 5'd0;
    rf_if.read_reg_2 = 5'd0;

    // 1: reset clears everything
    reset = 1'b1;
    step();
    reset = 1'b0;
    rf_if.read_reg_1 = 5'd16;
    rf_if.read_reg_2 = 5'd20;
    expect_val(K_RD1, "rst_rd1", 32'd0);
    expect_val(K_RD2, "rst_rd2", 32'd0);
    expect_val(K_COUNT, "rst_count", 32'd0);
    expect_val(K_STALL, "rst_stall", 32'd0);
    drain();

    // 2: write r16 with bypass visible in the write cycle, stored after edge
    wr(5'd16, 32'd1234567);
    expect_val(K_RD1, "byp_rd1_same", 32'd1234567);
    expect_val(K_RD2, "byp_rd2_other", 32'd0);
    drain();
    step();
    idle();
    expect_val(K_RD1, "wr_rd1_after", 32'd1234567);
    expect_val(K_COUNT, "wr_nonpend_count", 32'd0);
    drain();

    // 3: r0 stays zero even when written and bypass-read; $v0 tap
    rf_if.read_reg_1 = 5'd0;
    wr(5'd0, 32'hDEAD_BEEF);
    expect_val(K_RD1, "r0_byp", 32'd0);
    drain();
    step();
    wr(5'd2, 32'd7654321);
    expect_val(K_V0, "v0_byp", 32'd7654321);
    drain();
    step();
    idle();
    expect_val(K_RD1, "r0_read", 32'd0);
    expect_val(K_V0, "v0_stored", 32'd7654321);
    drain();

    // 4: issue r8 -> pending, writeback clears with bypass
    iss(5'd8);
    step();
    idle();
    rf_if.read_reg_2 = 5'd8;
    expect_val(K_PEND2, "iss_pend2", 32'd1);
    expect_val(K_STALL, "iss_stall", 32'd1);
    expect_val(K_COUNT, "iss_count", 32'd1);
    drain();
    wr(5'd8, 32'd42);
    expect_val(K_STALL, "wb_stall_same", 32'd0);
    expect_val(K_RD2, "wb_rd2_same", 32'd42);
    drain();
    step();
    idle();
    expect_val(K_COUNT, "wb_count_after", 32'd0);
    expect_val(K_PEND2, "wb_pend2_after", 32'd0);
    drain();

    // issue to r0 is ignored
    iss(5'd0);
    step();
    idle();
    rf_if.read_reg_1 = 5'd0;
    expect_val(K_COUNT, "iss_r0_count", 32'd0);
    expect_val(K_PEND1, "iss_r0_pend", 32'd0);
    drain();

    // 5: set wins over clear on the same register
    iss(5'd8);
    step();
    idle();
    iss(5'd8);
    wr(5'd8, 32'd5);
    step();
    idle();
    expect_val(K_RD2, "coll_rd2", 32'd5);
    expect_val(K_PEND2, "coll_pend2", 32'd1);
    expect_val(K_COUNT, "coll_count", 32'd1);
    drain();
    // issue r9 + retire r8 on one edge
    iss(5'd9);
    wr(5'd8, 32'd6);
    step();
    idle();
    rf_if.read_reg_1 = 5'd9;
    expect_val(K_PEND1, "swap_pend9", 32'd1);
    expect_val(K_PEND2, "swap_pend8", 32'd0);
    expect_val(K_RD2, "swap_rd2", 32'd6);
    expect_val(K_COUNT, "swap_count", 32'd1);
    drain();
    // WAW: reissue r9 keeps count
    iss(5'd9);
    step();
    idle();
    expect_val(K_COUNT, "waw_count", 32'd1);
    expect_val(K_STALL, "waw_stall", 32'd1);
    drain();

    // 6: issue r3,r4,r5 then reset with a concurrent write and issue
    for (int i = 3; i <= 5; i++) begin
      iss(5'(i));
      step();
    end
    idle();
    rf_if.read_reg_2 = 5'd4;
    expect_val(K_COUNT, "multi_count", 32'd4);
    expect_val(K_PEND2, "multi_pend4", 32'd1);
    drain();
    reset = 1'b1;
    wr(5'd3, 32'd99);
    iss(5'd6);
    step();
    reset = 1'b0;
    idle();
    rf_if.read_reg_1 = 5'd3;
    rf_if.read_reg_2 = 5'd9;
    expect_val(K_RD1, "rst2_rd1", 32'd0);
    expect_val(K_PEND1, "rst2_pend1", 32'd0);
    expect_val(K_PEND2, "rst2_pend2", 32'd0);
    expect_val(K_STALL, "rst2_stall", 32'd0);
    expect_val(K_COUNT, "rst2_count", 32'd0);
    expect_val(K_V0, "rst2_v0", 32'd0);
    drain();
    rf_if.read_reg_1 = 5'd16;
    expect_val(K_RD1, "rst2_r16", 32'd0);
    drain();
    // late writeback after reset is a plain write
    wr(5'd3, 32'd77);
    step();
    idle();
    rf_if.read_reg_1 = 5'd3;
    expect_val(K_RD1, "late_wb_rd1", 32'd77);
    expect_val(K_COUNT, "late_wb_count", 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
